// File: rtl/i2c_slave_responder.sv
// I2C target at SLV_ADDR with a DEPTH-byte register file: write sets pointer then data, read streams from pointer.
// Bus events act 3 pclk after the pin edge; SDA is driven open-drain only and SCL is never stretched.
module i2c_slave_responder #(
   parameter logic [6:0] SLV_ADDR = 7'h42,
   parameter int         DEPTH    = 8,
   parameter int         PTR_W    = $clog2(DEPTH)
) (
   input  logic             pclk_i,
   input  logic             preset_n_i,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe_o,
   output logic             start_o,
   output logic             stop_o,
   output logic             busy_o,
   output logic             wr_valid_o,
   output logic [PTR_W-1:0] wr_addr_o,
   output logic [7:0]       wr_data_o
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, DATA_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   state_t           state;
   logic             scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
   logic             scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]       shift_q;
   logic [7:0]       regs [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [3:0]       cnt;
   logic             rw;
   logic             ack_on;
   logic [7:0]       rx_byte;
   logic [7:0]       rd_byte;

   // Idle bus is high, so the synchronizers reset to 1 to avoid a false edge at release.
   always_ff @(posedge pclk_i or negedge preset_n_i) begin
      if (!preset_n_i) begin
         scl_m <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
         sda_m <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
      end else begin
         scl_m <= scl_i; scl_s <= scl_m; scl_d <= scl_s;
         sda_m <= sda_i; sda_s <= sda_m; sda_d <= sda_s;
      end
   end

   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & sda_d & ~sda_s;
   assign stop_det  = scl_s & ~sda_d & sda_s;
   assign rx_byte   = {shift_q[6:0], sda_s};
   assign rd_byte   = regs[ptr];

   always_ff @(posedge pclk_i or negedge preset_n_i) begin
      if (!preset_n_i) begin
         state      <= IDLE;
         sda_oe_o   <= 1'b0;
         start_o    <= 1'b0;
         stop_o     <= 1'b0;
         busy_o     <= 1'b0;
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= 8'h00;
         shift_q    <= 8'h00;
         ptr        <= '0;
         cnt        <= 4'd0;
         rw         <= 1'b0;
         ack_on     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
      end else begin
         start_o    <= 1'b0;
         stop_o     <= 1'b0;
         wr_valid_o <= 1'b0;
         if (start_det) begin
            state    <= ADDR;
            cnt      <= 4'd0;
            ack_on   <= 1'b0;
            sda_oe_o <= 1'b0;
            start_o  <= 1'b1;
         end else if (stop_det) begin
            state    <= IDLE;
            ack_on   <= 1'b0;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
            stop_o   <= 1'b1;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  shift_q <= rx_byte;
                  cnt     <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt <= 4'd0;
                     rw  <= sda_s;
                     if (rx_byte[7:1] == SLV_ADDR) begin
                        state <= ADDR_ACK;
                     end else begin
                        state  <= WAIT_STOP;
                        busy_o <= 1'b0;
                     end
                  end
               end
               // First fall drives the ACK, second fall ends it; a read presents its MSB on that same fall.
               ADDR_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     ack_on   <= 1'b1;
                     sda_oe_o <= 1'b1;
                     busy_o   <= 1'b1;
                  end else begin
                     ack_on <= 1'b0;
                     if (rw) begin
                        sda_oe_o <= ~rd_byte[7];
                        shift_q  <= {rd_byte[6:0], 1'b0};
                        cnt      <= 4'd1;
                        state    <= RD_DATA;
                     end else begin
                        sda_oe_o <= 1'b0;
                        cnt      <= 4'd0;
                        state    <= PTR;
                     end
                  end
               end
               PTR, WR_DATA: if (scl_rise) begin
                  shift_q <= rx_byte;
                  cnt     <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt   <= 4'd0;
                     state <= DATA_ACK;
                     if (state == PTR) begin
                        ptr <= rx_byte[PTR_W-1:0];
                     end else begin
                        regs[ptr]  <= rx_byte;
                        wr_valid_o <= 1'b1;
                        wr_addr_o  <= ptr;
                        wr_data_o  <= rx_byte;
                        ptr        <= ptr + 1'b1;
                     end
                  end
               end
               DATA_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     ack_on   <= 1'b1;
                     sda_oe_o <= 1'b1;
                  end else begin
                     ack_on   <= 1'b0;
                     sda_oe_o <= 1'b0;
                     state    <= WR_DATA;
                  end
               end
               // cnt counts bits already presented; the fall after the 8th bit hands SDA to the master.
               RD_DATA: if (scl_fall) begin
                  if (cnt == 4'd8) begin
                     sda_oe_o <= 1'b0;
                     ptr      <= ptr + 1'b1;
                     state    <= RD_ACK;
                  end else begin
                     sda_oe_o <= ~shift_q[7];
                     shift_q  <= {shift_q[6:0], 1'b0};
                     cnt      <= cnt + 4'd1;
                  end
               end
               RD_ACK: if (scl_rise) begin
                  if (!sda_s) begin
                     shift_q <= rd_byte;
                     cnt     <= 4'd0;
                     state   <= RD_DATA;
                  end else begin
                     state <= WAIT_STOP;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
